arcade_input_decoder: RTL

- Sits directly upstream of the game core's player-input pins, between hps_io (ps2_key, joystick_0/1) and the core.
- Decodes PS/2 key events into held-key state and merges it with both joysticks.
- Cleans opposing directions (SOCD) and shapes coin inputs into fixed-width, rate-limited pulses the core's coin counter can sample reliably.
- Outputs are active-high and registered; the top level inverts them where the core needs it.

---
 rtl/arcade_input_decoder.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/arcade_input_decoder.sv
// Player-input front end: PS/2 held-key decode merged with both pads,
// SOCD cleaning on directions and rate-limited fixed-width coin pulses.
module arcade_input_decoder #(
  parameter logic [15:0] COIN_HOLD    = 16'd1800,
  parameter logic [15:0] COIN_GAP     = 16'd1800,
  parameter bit          SOCD_NEUTRAL = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        key_clear,
  output logic        start1,
  output logic        start2,
  output logic        coin1,
  output logic        coin2,
  output logic        service,
  output logic        key_reset,
  output logic        pause,
  output logic        up1,
  output logic        down1,
  output logic        left1,
  output logic        right1,
  output logic        fire1,
  output logic        bomb1,
  output logic        up2,
  output logic        down2,
  output logic        left2,
  output logic        right2,
  output logic        fire2,
  output logic        bomb2
);

  typedef struct packed {
    logic start1, start2, coin1, coin2, rst, service, fire1, bomb1;
    logic up1, down1, left1, right1;
    logic up2, down2, left2, right2;
    logic fire2, bomb2, pause;
  } keys_t;

  typedef enum logic [1:0] {LAST_NONE, LAST_A, LAST_B} last_t;
  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_WAIT_REL, C_GAP} coin_t;

  keys_t      key_q, key_nxt;
  logic       prev_toggle_q, armed_q, evt;
  logic [1:0][3:0] dir_raw, dir_out;
  logic [1:0] coin_out;
  logic       unused_bits;

  assign unused_bits = ^{joystick_0[15:10], joystick_1[15:10]};
  assign evt = armed_q & (ps2_key[10] ^ prev_toggle_q);

  // Toggle history is only trusted from the first clock after reset release.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prev_toggle_q <= 1'b0;
      armed_q       <= 1'b0;
      key_q         <= '0;
    end else begin
      prev_toggle_q <= ps2_key[10];
      armed_q       <= 1'b1;
      key_q         <= key_nxt;
    end
  end

  always_comb begin
    key_nxt = key_q;
    if (key_clear) begin
      key_nxt = '0;
    end else if (evt) begin
      case (ps2_key[7:0])
        8'h75: key_nxt.up1    = ps2_key[9];
        8'h72: key_nxt.down1  = ps2_key[9];
        8'h6B: key_nxt.left1  = ps2_key[9];
        8'h74: key_nxt.right1 = ps2_key[9];
        8'h16: if (!ps2_key[8]) key_nxt.start1  = ps2_key[9];
        8'h1E: if (!ps2_key[8]) key_nxt.start2  = ps2_key[9];
        8'h2E: if (!ps2_key[8]) key_nxt.coin1   = ps2_key[9];
        8'h36: if (!ps2_key[8]) key_nxt.coin2   = ps2_key[9];
        8'h04: if (!ps2_key[8]) key_nxt.rst     = ps2_key[9];
        8'h46: if (!ps2_key[8]) key_nxt.service = ps2_key[9];
        8'h14: if (!ps2_key[8]) key_nxt.fire1   = ps2_key[9];
        8'h11: if (!ps2_key[8]) key_nxt.bomb1   = ps2_key[9];
        8'h2D: if (!ps2_key[8]) key_nxt.up2     = ps2_key[9];
        8'h23: if (!ps2_key[8]) key_nxt.left2   = ps2_key[9];
        8'h2B: if (!ps2_key[8]) key_nxt.down2   = ps2_key[9];
        8'h34: if (!ps2_key[8]) key_nxt.right2  = ps2_key[9];
        8'h1C: if (!ps2_key[8]) key_nxt.fire2   = ps2_key[9];
        8'h1B: if (!ps2_key[8]) key_nxt.bomb2   = ps2_key[9];
        8'h4D: if (!ps2_key[8]) key_nxt.pause   = ps2_key[9];
        default: ;
      endcase
    end
  end

  // Merge uses the post-event key state so keys share the pads' latency.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      start1    <= 1'b0;
      start2    <= 1'b0;
      pause     <= 1'b0;
      service   <= 1'b0;
      key_reset <= 1'b0;
      fire1     <= 1'b0;
      bomb1     <= 1'b0;
      fire2     <= 1'b0;
      bomb2     <= 1'b0;
    end else begin
      start1    <= joystick_0[6] | joystick_1[7] | key_nxt.start1;
      start2    <= joystick_1[6] | joystick_0[7] | key_nxt.start2;
      pause     <= joystick_0[9] | joystick_1[9] | key_nxt.pause;
      service   <= key_nxt.service;
      key_reset <= key_nxt.rst;
      fire1     <= joystick_0[4] | key_nxt.fire1;
      bomb1     <= joystick_0[5] | key_nxt.bomb1;
      fire2     <= joystick_1[4] | key_nxt.fire2;
      bomb2     <= joystick_1[5] | key_nxt.bomb2;
    end
  end

  assign dir_raw[0] = joystick_0[3:0] | {key_nxt.up1, key_nxt.down1, key_nxt.left1, key_nxt.right1};
  assign dir_raw[1] = joystick_1[3:0] | {key_nxt.up2, key_nxt.down2, key_nxt.left2, key_nxt.right2};

  for (genvar p = 0; p < 2; p++) begin : g_player
    for (genvar ax = 0; ax < 2; ax++) begin : g_axis
      localparam int HI = 3 - 2 * ax;
      localparam int LO = 2 - 2 * ax;
      logic  a_raw, b_raw, a_q, b_q, a_out, b_out;
      last_t last_q, last_nxt;

      assign a_raw = dir_raw[p][HI];
      assign b_raw = dir_raw[p][LO];

      // Rising edges are taken against stage 1 so 'last' lines up with a_q/b_q.
      always_comb begin
        last_nxt = last_q;
        if (a_raw && !a_q && b_raw && !b_q) last_nxt = LAST_NONE;
        else if (a_raw && !a_q)             last_nxt = LAST_A;
        else if (b_raw && !b_q)             last_nxt = LAST_B;
      end

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          last_q <= LAST_NONE;
          a_out  <= 1'b0;
          b_out  <= 1'b0;
        end else begin
          a_q    <= a_raw;
          b_q    <= b_raw;
          last_q <= last_nxt;
          if (!(a_q && b_q)) begin
            a_out <= a_q;
            b_out <= b_q;
          end else if (SOCD_NEUTRAL) begin
            a_out <= 1'b0;
            b_out <= 1'b0;
          end else begin
            a_out <= (last_q == LAST_A);
            b_out <= (last_q == LAST_B);
          end
        end
      end

      assign dir_out[p][HI] = a_out;
      assign dir_out[p][LO] = b_out;
    end
  end

  assign {up1, down1, left1, right1} = dir_out[0];
  assign {up2, down2, left2, right2} = dir_out[1];

  for (genvar c = 0; c < 2; c++) begin : g_coin
    coin_t       state_q, state_nxt;
    logic [15:0] cnt_q, cnt_nxt;
    logic        raw, raw_q;

    assign raw = (c == 0) ? (joystick_0[8] | key_nxt.coin1) : (joystick_1[8] | key_nxt.coin2);

    // raw_q resets high so a coin held through reset needs a fresh press.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= C_IDLE;
        cnt_q   <= '0;
        raw_q   <= 1'b1;
      end else begin
        state_q <= state_nxt;
        cnt_q   <= cnt_nxt;
        raw_q   <= raw;
      end
    end

    always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      case (state_q)
        C_IDLE:
          if (raw && !raw_q) begin
            cnt_nxt   = COIN_HOLD - 16'd1;
            state_nxt = C_PULSE;
          end
        C_PULSE:
          if (cnt_q == '0) state_nxt = C_WAIT_REL;
          else             cnt_nxt   = cnt_q - 16'd1;
        C_WAIT_REL:
          if (!raw) begin
            if (COIN_GAP == '0) begin
              state_nxt = C_IDLE;
            end else begin
              cnt_nxt   = COIN_GAP;
              state_nxt = C_GAP;
            end
          end
        C_GAP: begin
          cnt_nxt = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_nxt = C_IDLE;
        end
        default: state_nxt = C_IDLE;
      endcase
    end

    assign coin_out[c] = (state_q == C_PULSE);
  end

  assign coin1 = coin_out[0];
  assign coin2 = coin_out[1];

endmodule
